// File: rtl/dffre_pkg.sv
// Shared definitions for the dffre pipe family: occupancy-count width helper
// and the common valid/data handshake bundle.
package dffre_pkg;

  localparam int HS_DATA_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [HS_DATA_W-1:0] data;
  } hs_t;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/dffre_pipe_stage.sv
// One pipeline slot: a valid bit plus a data register. Flush clears only the
// valid bit; data is touched only on load or reset.
module dffre_pipe_stage #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  // valid bit: load wins over clear so a simultaneous pop and refill stays full
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  // data register: stale contents of an emptied slot are held
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= RESET_VAL;
    end else if (!flush && load) begin
      data_r <= load_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/dffre_pipe.sv
// Multi-stage valid/ready pipeline register with bubble collapsing, flush,
// programmable reset value and a registered occupancy count.
module dffre_pipe
  import dffre_pkg::*;
#(
  parameter  int               WIDTH     = 32,
  parameter  int               STAGES    = 2,
  parameter  logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  localparam int               CNT_W     = cnt_width(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] count
);

  logic [STAGES-1:0] v_s;
  logic [STAGES-1:0] adv_s;
  logic [STAGES-1:0] load_s;
  logic [STAGES-1:0] nv_s;
  logic [WIDTH-1:0]  data_s [STAGES];
  logic              carry_s;
  logic              in_ready_s;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [CNT_W-1:0]  count_r;

  // advance chain, walked from the output end so a stage may fill a hole
  // ahead of it even while the stages behind the hole stall
  always_comb begin
    adv_s            = {STAGES{1'b0}};
    carry_s          = v_s[STAGES-1] & out_ready;
    adv_s[STAGES-1]  = carry_s;
    for (int i = STAGES - 2; i >= 0; i--) begin
      carry_s  = v_s[i] & (~v_s[i+1] | carry_s);
      adv_s[i] = carry_s;
    end
  end

  assign in_ready_s = ~v_s[0] | adv_s[0];

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    logic [WIDTH-1:0] src_s;
    if (g == 0) begin : g_head
      assign load_s[g] = in_valid & in_ready_s;
      assign src_s     = in_data;
    end else begin : g_body
      assign load_s[g] = adv_s[g-1];
      assign src_s     = data_s[g-1];
    end

    dffre_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .load      (load_s[g]),
      .clear     (adv_s[g]),
      .load_data (src_s),
      .valid     (v_s[g]),
      .data      (data_s[g])
    );
  end

  // popcount of the post-edge valid vector, so count tracks the valid bits
  always_comb begin
    nv_s      = load_s | (v_s & ~adv_s);
    cnt_nxt_s = {CNT_W{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      cnt_nxt_s = cnt_nxt_s + CNT_W'(nv_s[i]);
    end
  end

  // occupancy count register
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= {CNT_W{1'b0}};
    end else if (flush) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      count_r <= cnt_nxt_s;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = v_s[STAGES-1];
  assign out_data  = data_s[STAGES-1];
  assign count     = count_r;

endmodule

// File: tb/tb_dffre_pipe.sv
// Scoreboard bench for dffre_pipe (WIDTH=8, STAGES=3, RESET_VAL=8'hA5):
// accepted inputs are queued, an output monitor pops and compares in order.
module tb_dffre_pipe;

  localparam int         WIDTH  = 8;
  localparam int         STAGES = 3;
  localparam logic [7:0] RV     = 8'hA5;
  localparam int         CNT_W  = 2;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready;
  logic             in_ready, out_valid;
  logic [WIDTH-1:0] in_data, out_data;
  logic [CNT_W-1:0] count;

  logic [WIDTH-1:0] exp_q [$];
  logic [WIDTH-1:0] exp_d;
  int               n_pass  = 0;
  int               n_total = 0;
  int               pop_cnt = 0;

  dffre_pipe #(
    .WIDTH     (WIDTH),
    .STAGES    (STAGES),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // input side of the scoreboard: record every accepted item
  always @(negedge clk) begin
    if (!rst && !flush && in_valid && in_ready) exp_q.push_back(in_data);
  end

  // output side: pop and compare on every downstream transfer
  always @(negedge clk) begin
    if (rst || flush) begin
      exp_q.delete();
    end else if (out_valid && out_ready) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_out: got %0h expected no output", out_data);
      end else begin
        exp_d = exp_q.pop_front();
        chk("out_order", {24'd0, out_data}, {24'd0, exp_d});
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    next(); next();
    rst = 1'b0;
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", {24'd0, out_data}, 32'hA5);
    chk("rst_count", {30'd0, count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // streaming 0x01..0x0A
    next();
    out_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      #2;
      chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
      chk("stream_count", {30'd0, count}, (k - 1 < 3) ? 32'(k - 1) : 32'd3);
      chk("stream_latency", {31'd0, out_valid}, (k >= 4) ? 32'd1 : 32'd0);
      next();
    end
    in_valid = 1'b0;
    next(); next(); next();
    #2;
    chk("drain_count", {30'd0, count}, 32'd0);
    chk("drain_pops", 32'(pop_cnt), 32'd10);

    // stall and collapse
    next();
    out_ready = 1'b0;
    in_valid  = 1'b1; in_data = 8'h11; #2; chk("stall_rdy_11", {31'd0, in_ready}, 32'd1); next();
    in_data   = 8'h22;                #2; chk("stall_rdy_22", {31'd0, in_ready}, 32'd1); next();
    in_data   = 8'h33;                #2; chk("stall_rdy_33", {31'd0, in_ready}, 32'd1); next();
    in_data   = 8'h44;                #2;
    chk("stall_rdy_44", {31'd0, in_ready}, 32'd0);
    chk("stall_count", {30'd0, count}, 32'd3);
    chk("stall_out_data", {24'd0, out_data}, 32'h11);
    next();
    #2;
    chk("stall_hold_data", {24'd0, out_data}, 32'h11);
    chk("stall_hold_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    #1;
    chk("pushpop_rdy", {31'd0, in_ready}, 32'd1);
    next();
    out_ready = 1'b0; in_valid = 1'b0;
    #2;
    chk("pushpop_count", {30'd0, count}, 32'd3);
    chk("pushpop_data", {24'd0, out_data}, 32'h22);
    out_ready = 1'b1;
    next(); next(); next();
    #2;
    chk("stall_drained", {30'd0, count}, 32'd0);

    // bubble collapse
    next();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h55; next();
    in_valid = 1'b0;                  next();
    in_valid = 1'b1; in_data = 8'h66; next();
    in_valid = 1'b0;                  next();
    #2;
    chk("bubble_count", {30'd0, count}, 32'd2);
    chk("bubble_out_data", {24'd0, out_data}, 32'h55);
    chk("bubble_in_ready", {31'd0, in_ready}, 32'd1);

    // flush with a full pipe and an input presented
    next();
    in_valid = 1'b1; in_data = 8'h70; next();
    #2;
    chk("pre_flush_count", {30'd0, count}, 32'd3);
    flush = 1'b1; in_data = 8'h77;
    next();
    flush = 1'b0; in_valid = 1'b0;
    #2;
    chk("flush_count", {30'd0, count}, 32'd0);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_data_kept", {24'd0, out_data}, 32'h55);
    // flush while in_ready reads 1: the input is still dropped
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h78;
    #1;
    chk("flush_in_ready", {31'd0, in_ready}, 32'd1);
    next();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #2;
    chk("flush2_count", {30'd0, count}, 32'd0);
    next(); next(); next(); next();
    #2;
    chk("flush_no_output", {31'd0, out_valid}, 32'd0);

    // reset mid-stream
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 8'h81; next();
    in_data  = 8'h82;                 next();
    in_valid = 1'b0;                  next();
    #2;
    chk("mid_count", {30'd0, count}, 32'd2);
    chk("mid_out_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    next();
    rst = 1'b0;
    #2;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_out_data", {24'd0, out_data}, 32'hA5);
    chk("mrst_count", {30'd0, count}, 32'd0);
    chk("mrst_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    next();
    in_valid = 1'b0;
    #2; chk("lat99_c1", {31'd0, out_valid}, 32'd0);
    next();
    #2; chk("lat99_c2", {31'd0, out_valid}, 32'd0);
    next();
    #2;
    chk("lat99_c3", {31'd0, out_valid}, 32'd1);
    chk("lat99_data", {24'd0, out_data}, 32'h99);
    next(); next();
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("final_pops", 32'(pop_cnt), 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/dffre_pipe.md
Name: dffre_pipe

Overview:
Parametrised multi-stage pipeline register. It is the successor to the plain single-flop register and adds per-stage valid bits, a valid/ready handshake, bubble collapsing, flush, a programmable reset value and an occupancy count. It is used wherever a datapath needs STAGES cycles of retiming with backpressure, for example between the decode and execute units.

Parameters:
WIDTH, 32, data bits per stage; must be ≥1.
STAGES, 2, number of register stages; must be ≥1.
RESET_VAL, '0, WIDTH-bit value loaded into every data register at reset.
CNT_W, $clog2(STAGES+1), width of the occupancy count; derived, not overridden.

Ports:
clk  in  1  rising-edge clock.
rst  in  1  synchronous, active-high reset.
flush  in  1  drops all held entries.
in_valid  in  1  upstream data valid.
in_ready  out  1  stage 0 can accept this cycle.
in_data  in  WIDTH  upstream data.
out_valid  out  1  last stage holds valid data.
out_ready  in  1  downstream accepts this cycle.
out_data  out  WIDTH  last-stage data register.
count  out  CNT_W  number of valid stages.

Behaviour:
- Clocking and reset
  - One clock, clk. Reset is synchronous and active-high on rst; all state changes only on the rising edge of clk.
  - rst dominates flush and all handshakes.
  - After a reset edge: every valid bit = 0, every data register = RESET_VAL, count = 0.
  - Therefore out_valid = 0 and out_data = RESET_VAL.
  - in_ready = 1 in the first cycle after reset (flush inactive).
- Stage state: valid bit v[i] and data d[i], for i = 0..STAGES-1. Stage STAGES-1 drives out_valid/out_data.
- Advance rule, combinational and evaluated from the last stage backwards:
  - adv[STAGES-1] = v[STAGES-1] & out_ready.
  - For i < STAGES-1: adv[i] = v[i] & (!v[i+1] | adv[i+1]). This is bubble collapsing: a stage fills if it is empty, even when later stages stall.
  - in_ready = !v[0] | adv[0]. There is a combinational path from out_ready to in_ready, with depth proportional to STAGES.
- Updates at the clock edge, when neither rst nor flush is asserted:
  - Stage 0 loads in_data and sets v[0] = 1 when in_valid & in_ready.
  - Otherwise v[0] clears if adv[0].
  - Stage i+1 loads d[i] when adv[i]; its valid bit follows the same pattern.
  - A data register changes only when it loads. Stale data in an empty stage is held, not cleared.
- Latency: STAGES cycles from input acceptance to out_valid when the pipe is not stalled. Throughput is 1 item/cycle with out_ready held at 1.
- count = popcount(v). It is registered and updated in the same cycle as the valid bits.
  - Full: count = STAGES, in_ready = 0 unless adv[0].
  - Full with out_ready = 1: a simultaneous push and pop keeps count = STAGES.
- flush = 1:
  - All v ← 0 at the next edge; count ← 0.
  - Any input presented in the same cycle is dropped, even though in_ready may read 1.
  - Data registers are not altered.
  - in_ready is not gated by flush, so no combinational path from flush to in_ready.
- Handshake rules:
  - out_data is stable while out_valid & !out_ready.
  - in_valid may be withdrawn without protocol violation; the block never relies on it being held.
- Reset mid-operation: all in-flight entries are lost and no partial transfer occurs. The upstream must treat the rst cycle as non-accepting.
- STAGES = 1 degenerates to a single-entry register slice with the same rules.

Decomposition:
- A shared package, dffre_pkg, holds:
  - the count-width helper function (clog2 of N+1);
  - the common handshake struct typedef {valid, data}, for reuse by sibling pipe blocks.
- One natural sub-module, dffre_pipe_stage: one valid bit plus one WIDTH-bit register with load/clear/flush inputs. It is instantiated STAGES times in a generate loop.
- The advance chain and count live in the top module.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with WIDTH = 8, RESET_VAL = 8'hA5, STAGES = 3 -> out_valid = 0, out_data = 8'hA5, count = 0, in_ready = 1.
- Streaming: push 0x01..0x0A back-to-back with out_ready = 1 -> first out_valid exactly 3 cycles after the first accept; outputs 0x01..0x0A in order, one per cycle; count steady at 3.
- Stall and collapse: out_ready = 0, push 0x11, 0x22, 0x33, 0x44 -> 0x11..0x33 accepted, in_ready = 0 at 4th; count = 3; out_data held at 0x11. Then raise out_ready for 1 cycle -> 0x44 accepted in that same cycle, count stays 3.
- Bubble collapse: push 0x55, idle 1 cycle, push 0x66, out_ready = 0 -> both occupy the last two stages; count = 2.
- Flush: with count = 3, assert flush together with in_valid = 1 and in_data = 0x77 -> next cycle count = 0, out_valid = 0; 0x77 never appears at the output.
- Reset mid-stream: assert rst while count = 2 and out_valid = 1 -> next cycle all valids = 0, out_data = RESET_VAL; a subsequent push of 0x99 emerges after 3 cycles.
